uart_tx: RTL and testbench

Serial UART transmitter: accepts a parallel data word on a one-cycle start strobe and shifts it out on `tx_o` as an 8N1 (or 8E1) frame, LSB first. The bit timing is derived from `sysclk` through the same prescaler and DIV-tick bit-period scheme the board's UART receiver uses, so a loopback of `tx_o` into that receiver runs at a matching baud rate. It sits between the board's host/command logic and the serial pin.

---
 rtl/uart_tx_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_tx.sv | 148 ++++++++++++++
 tb/tb_uart_tx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_tx_pkg                                              |
// | Brief    : Shared UART definitions: one-hot state encodings and the |
// |            even-parity helper used by both transmitter and receiver.|
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package uart_tx_pkg;

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int c_PAR_MAX_W = 32;

  // One-hot frame states, shared with the receiver.
  typedef enum logic [4:0] {
    ST_IDLE       = 5'b00001,
    ST_START_BIT  = 5'b00010,
    ST_BITS       = 5'b00100,
    ST_PARITY_BIT = 5'b01000,
    ST_STOP_BIT   = 5'b10000
  } uart_state_e;

  // Even parity bit: XOR of all data bits (zero padding does not change it).
  function automatic logic even_parity(input logic [c_PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_baud_tick                                           |
// | Brief    : Prescaler counting 0..PSCALER-1; tick_o is high in the   |
// |            cycle the count wraps. clear_i holds the count at zero.  |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module uart_baud_tick #(
  parameter int PSCALER = 1
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int c_PW = (PSCALER > 1) ? $clog2(PSCALER) : 1;
  localparam logic [c_PW-1:0] c_LAST = c_PW'(PSCALER - 1);

  logic [c_PW-1:0] r_cnt;

  // With PSCALER=1 the count never leaves zero, so a tick is issued every cycle.
  assign tick_o = (r_cnt == c_LAST);

  // Prescaler count: restart from zero on clear, wrap after PSCALER cycles.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear_i || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_tx                                                  |
// | Brief    : UART transmitter, 8N1 / 8E1 frames, LSB first. Bit period |
// |            is PSCALER*DIV sysclk cycles. All outputs registered.    |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int N       = 8,   // data width, at most c_PAR_MAX_W
  parameter int PSCALER = 1,
  parameter int DIV     = 10
) (
  input  logic         sysclk,
  input  logic         reset_n,
  input  logic         tx_start_i,
  input  logic [N-1:0] tx_data_i,
  input  logic         parity_i,
  output logic         tx_o,
  output logic         tx_busy_o,
  output logic         tx_end_o
);

  localparam int c_TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(DIV - 1);
  localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(N - 1);

  uart_state_e     r_state, w_state_next;
  logic [c_TW-1:0] r_tick_cnt, w_tick_cnt_next;
  logic [c_BW-1:0] r_bit_cnt, w_bit_cnt_next;
  logic [N-1:0]    r_data, w_data_next;
  logic            r_par_en, w_par_en_next;
  logic            r_par, w_par_next;
  logic            w_tick;
  logic            w_idle;
  logic            w_cell_done;
  logic            w_tx_next;
  logic            w_busy_next;
  logic            w_end_next;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_cell_done = w_tick && (r_tick_cnt == c_TICK_LAST);

  // Prescaler held at zero while idle so the start bit is a full cell.
  uart_baud_tick #(
    .PSCALER (PSCALER)
  ) u_baud_tick (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .clear_i (w_idle),
    .tick_o  (w_tick)
  );

  // Next-state, counter and next-output decode.
  always_comb begin
    w_state_next    = r_state;
    w_tick_cnt_next = r_tick_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_data_next     = r_data;
    w_par_en_next   = r_par_en;
    w_par_next      = r_par;
    w_end_next      = 1'b0;

    if (!w_idle && w_tick) begin
      w_tick_cnt_next = w_cell_done ? '0 : r_tick_cnt + 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        w_tick_cnt_next = '0;
        w_bit_cnt_next  = '0;
        if (tx_start_i) begin
          w_data_next   = tx_data_i;
          w_par_en_next = parity_i;
          w_par_next    = even_parity(c_PAR_MAX_W'(tx_data_i));
          w_state_next  = ST_START_BIT;
        end
      end
      ST_START_BIT: begin
        if (w_cell_done) begin
          w_state_next   = ST_BITS;
          w_bit_cnt_next = '0;
        end
      end
      ST_BITS: begin
        if (w_cell_done) begin
          if (r_bit_cnt == c_BIT_LAST) begin
            w_state_next = r_par_en ? ST_PARITY_BIT : ST_STOP_BIT;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY_BIT: begin
        if (w_cell_done) begin
          w_state_next = ST_STOP_BIT;
        end
      end
      ST_STOP_BIT: begin
        if (w_cell_done) begin
          w_state_next = ST_IDLE;
          w_end_next   = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Line level is derived from the state being entered so tx_o is a flop.
    case (w_state_next)
      ST_START_BIT:  w_tx_next = 1'b0;
      ST_BITS:       w_tx_next = w_data_next[w_bit_cnt_next];
      ST_PARITY_BIT: w_tx_next = w_par_next;
      default:       w_tx_next = 1'b1;
    endcase
    w_busy_next = (w_state_next != ST_IDLE);
  end

  // State, counters, latched word and registered outputs.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par      <= 1'b0;
      tx_o       <= 1'b1;
      tx_busy_o  <= 1'b0;
      tx_end_o   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_data     <= w_data_next;
      r_par_en   <= w_par_en_next;
      r_par      <= w_par_next;
      tx_o       <= w_tx_next;
      tx_busy_o  <= w_busy_next;
      tx_end_o   <= w_end_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_uart_tx                                               |
// | Brief    : Self-checking bench for uart_tx; two instances with      |
// |            different bit timing checked against a frame model.      |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_uart_tx;

  localparam int c_T0 = 1 * 10;  // instance 0: PSCALER=1, DIV=10
  localparam int c_T1 = 3 * 4;   // instance 1: PSCALER=3, DIV=4

  logic       sysclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       parity = 1'b0;
  logic       sel = 1'b0;

  logic start0, start1;
  logic tx0, busy0, end0;
  logic tx1, busy1, end1;
  logic tx_m, busy_m, end_m;

  int total = 0;
  int bad   = 0;

  assign start0 = tx_start & ~sel;
  assign start1 = tx_start & sel;
  assign tx_m   = sel ? tx1 : tx0;
  assign busy_m = sel ? busy1 : busy0;
  assign end_m  = sel ? end1 : end0;

  always #5 sysclk = ~sysclk;

  uart_tx #(.N(8), .PSCALER(1), .DIV(10)) u_dut0 (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .tx_start_i (start0),
    .tx_data_i  (tx_data),
    .parity_i   (parity),
    .tx_o       (tx0),
    .tx_busy_o  (busy0),
    .tx_end_o   (end0)
  );

  uart_tx #(.N(8), .PSCALER(3), .DIV(4)) u_dut1 (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .tx_start_i (start1),
    .tx_data_i  (tx_data),
    .parity_i   (parity),
    .tx_o       (tx1),
    .tx_busy_o  (busy1),
    .tx_end_o   (end1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Idle cycles: line high, not busy, no end pulse.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      chk("idle_tx", tx_m, 1);
      chk("idle_busy", busy_m, 0);
      chk("idle_end", end_m, 0);
    end
  endtask

  // Sends one word from an idle (or end-pulse) cycle and checks the whole frame
  // cell by cell. keep_start leaves the strobe high throughout, so the word
  // present at the end-pulse cycle is accepted by the next call.
  task automatic run_frame(input logic [7:0] d, input logic p, input bit keep_start);
    logic exp_bits [0:10];
    int   t;
    int   len;
    t   = sel ? c_T1 : c_T0;
    len = p ? 11 : 10;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1+i] = d[i];
    exp_bits[9]     = ^d;
    exp_bits[len-1] = 1'b1;

    tx_start = 1'b1;
    tx_data  = d;
    parity   = p;
    @(posedge sysclk);
    for (int j = 1; j <= len * t; j++) begin
      @(negedge sysclk);
      chk("frame_tx", tx_m, exp_bits[(j-1)/t]);
      chk("frame_busy", busy_m, 1);
      chk("frame_end", end_m, 0);
      if (!keep_start) tx_start = 1'b0;
      tx_data = 8'($urandom);
      parity  = 1'($urandom);
    end
    @(negedge sysclk);
    chk("end_pulse", end_m, 1);
    chk("end_busy", busy_m, 0);
    chk("end_tx", tx_m, 1);
  endtask

  initial begin
    bit keep;

    // Reset state of both instances.
    repeat (3) @(negedge sysclk);
    chk("rst_tx0", tx0, 1);
    chk("rst_busy0", busy0, 0);
    chk("rst_end0", end0, 0);
    chk("rst_tx1", tx1, 1);
    chk("rst_busy1", busy1, 0);
    chk("rst_end1", end1, 0);
    reset_n = 1'b1;
    idle(2);

    // Directed frames at T=10.
    run_frame(8'hA5, 1'b0, 1'b0);
    idle(3);
    run_frame(8'h07, 1'b1, 1'b0);
    idle(1);
    run_frame(8'h03, 1'b1, 1'b0);
    idle(2);

    // Strobe held high: second word accepted in the end-pulse cycle.
    run_frame(8'h55, 1'b0, 1'b1);
    run_frame(8'hAA, 1'b0, 1'b0);
    idle(2);

    // Asynchronous reset in the middle of the data bits.
    tx_start = 1'b1;
    tx_data  = 8'h00;
    parity   = 1'b0;
    @(posedge sysclk);
    @(negedge sysclk);
    tx_start = 1'b0;
    repeat (44) @(negedge sysclk);
    chk("pre_rst_busy", busy0, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_tx", tx0, 1);
    chk("arst_busy", busy0, 0);
    chk("arst_end", end0, 0);
    @(negedge sysclk);
    reset_n = 1'b1;
    idle(2);
    run_frame(8'h3C, 1'b1, 1'b0);
    idle(1);

    // Random words at both bit timings, with random back-to-back chaining.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      idle(1);
      for (int i = 0; i < 20; i++) begin
        keep = (i < 19) ? bit'($urandom_range(0, 1)) : 1'b0;
        run_frame(8'($urandom), 1'($urandom), keep);
        if (!keep) idle($urandom_range(0, 3));
      end
      tx_start = 1'b0;
      idle(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
